// File: rtl/biquad_pkg.sv
// biquad_pkg: shared state, coefficient-set type and defaults for biquad_df1.
// Coefficient fields are CW bits wide; the filter sign-extends DW-bit inputs into them.
package biquad_pkg;

    localparam int Q_FP_DEF = 15;
    localparam int CW       = 32;
    localparam int NTAPS    = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    typedef struct packed {
        logic signed [CW-1:0] b0;
        logic signed [CW-1:0] b1;
        logic signed [CW-1:0] b2;
        logic signed [CW-1:0] a1;
        logic signed [CW-1:0] a2;
    } coef_t;

    // Unity-gain set: b0 = 1.0 in Q(q), everything else zero.
    function automatic coef_t coef_pass(input int q);
        coef_t c;
        c    = '0;
        c.b0 = CW'(1 << q);
        return c;
    endfunction

endpackage

// File: rtl/biquad_mac.sv
// biquad_mac: one signed multiplier feeding a 2*DW+3 bit accumulator.
// i_clr has priority over i_en; i_sub subtracts the product.
module biquad_mac
    import biquad_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic                   i_sub,
    input  logic signed [DW-1:0]   i_a,
    input  logic signed [DW-1:0]   i_b,
    output logic signed [2*DW+2:0] o_acc
);

    localparam int AW = 2 * DW + 3;

    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_term;
    logic signed [AW-1:0]   r_acc;

    assign w_prod = i_a * i_b;
    assign w_term = AW'(w_prod);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_sub ? (r_acc - w_term) : (r_acc + w_term);
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/biquad_df1.sv
// biquad_df1: direct-form-I biquad, five taps time-shared over one MAC.
// Define BIQUAD_SAT_EN to clamp the output instead of two's-complement wrap.
module biquad_df1
    import biquad_pkg::*;
#(
    parameter int DW   = 32,
    parameter int Q_FP = Q_FP_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic signed [DW-1:0] i_data,
    output logic                 o_valid,
    output logic signed [DW-1:0] o_data,
    input  logic                 i_coef_load,
    input  logic signed [DW-1:0] i_b0,
    input  logic signed [DW-1:0] i_b1,
    input  logic signed [DW-1:0] i_b2,
    input  logic signed [DW-1:0] i_a1,
    input  logic signed [DW-1:0] i_a2,
    input  logic                 i_clear
);

    localparam int AW = 2 * DW + 3;

    state_t               r_state;
    state_t               w_next;
    logic [2:0]           r_cnt;
    coef_t                r_shadow;
    coef_t                r_act;
    coef_t                w_coef_in;
    logic signed [DW-1:0] r_x0, r_x1, r_x2;
    logic signed [DW-1:0] r_y1, r_y2;
    logic signed [DW-1:0] r_data;
    logic signed [DW-1:0] w_y;
    logic signed [DW-1:0] w_tap_x;
    logic signed [DW-1:0] w_tap_c;
    logic signed [AW-1:0] w_acc;
    logic                 r_valid;
    logic                 r_clr_pend;
    logic                 w_ready;
    logic                 w_accept;
    logic                 w_mac_en;
    logic                 w_mac_clr;
    logic                 w_sub;

    assign w_coef_in = '{
        b0: CW'(i_b0),
        b1: CW'(i_b1),
        b2: CW'(i_b2),
        a1: CW'(i_a1),
        a2: CW'(i_a2)
    };

    assign w_accept = i_valid && w_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MAC;
            S_MAC:   if (r_cnt == 3'(NTAPS - 1)) w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Accumulator is held clear while idle, so the accept edge starts at zero.
    always_comb begin
        w_ready   = 1'b0;
        w_mac_en  = 1'b0;
        w_mac_clr = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready   = 1'b1;
                w_mac_clr = 1'b1;
            end
            S_MAC:   w_mac_en = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_tap_x = r_x0;
        w_tap_c = r_act.b0[DW-1:0];
        w_sub   = 1'b0;
        unique case (r_cnt)
            3'd0: ;
            3'd1: begin
                w_tap_x = r_x1;
                w_tap_c = r_act.b1[DW-1:0];
            end
            3'd2: begin
                w_tap_x = r_x2;
                w_tap_c = r_act.b2[DW-1:0];
            end
            3'd3: begin
                w_tap_x = r_y1;
                w_tap_c = r_act.a1[DW-1:0];
                w_sub   = 1'b1;
            end
            3'd4: begin
                w_tap_x = r_y2;
                w_tap_c = r_act.a2[DW-1:0];
                w_sub   = 1'b1;
            end
            default: ;
        endcase
    end

    biquad_mac #(
        .DW(DW)
    ) u_mac (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_mac_clr),
        .i_en    (w_mac_en),
        .i_sub   (w_sub),
        .i_a     (w_tap_c),
        .i_b     (w_tap_x),
        .o_acc   (w_acc)
    );

`ifdef BIQUAD_SAT_EN
    localparam logic signed [AW-1:0] MAXV =
        {{(AW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    logic signed [AW-1:0] w_shift;

    assign w_shift = w_acc >>> Q_FP;
    assign w_y = (w_shift > MAXV) ? MAXV[DW-1:0] :
                 (w_shift < MINV) ? MINV[DW-1:0] :
                 w_shift[DW-1:0];
`else
    assign w_y = DW'(w_acc >>> Q_FP);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_shadow   <= coef_pass(Q_FP);
            r_act      <= coef_pass(Q_FP);
            r_x0       <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_y1       <= '0;
            r_y2       <= '0;
            r_clr_pend <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= '0;
        end else begin
            r_cnt   <= (r_state == S_MAC) ? r_cnt + 3'd1 : 3'd0;
            r_valid <= (r_state == S_OUT);
            if (i_coef_load) begin
                r_shadow <= w_coef_in;
            end
            if (w_accept) begin
                r_act <= i_coef_load ? w_coef_in : r_shadow;
                r_x0  <= i_data;
            end
            // A clear seen mid-sample replaces the history shift at S_OUT.
            if (((r_state == S_IDLE) && i_clear) ||
                ((r_state == S_OUT) && (r_clr_pend || i_clear))) begin
                r_x1 <= '0;
                r_x2 <= '0;
                r_y1 <= '0;
                r_y2 <= '0;
            end else if (r_state == S_OUT) begin
                r_x2 <= r_x1;
                r_x1 <= r_x0;
                r_y2 <= r_y1;
                r_y1 <= w_y;
            end
            if (r_state == S_OUT) begin
                r_data     <= w_y;
                r_clr_pend <= 1'b0;
            end else if ((r_state == S_MAC) && i_clear) begin
                r_clr_pend <= 1'b1;
            end
        end
    end

    assign o_ready = w_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: tb/tb_biquad_df1.sv
// tb_biquad_df1: directed vectors against an arithmetic DF-I model.
// Model tracks handshake timing, coefficient shadowing and history itself.
module tb_biquad_df1;

    localparam int Q = 15;

`ifdef BIQUAD_SAT_EN
    localparam logic signed [31:0] BIGY = 32'sh7FFFFFFF;
`else
    localparam logic signed [31:0] BIGY = 32'shFFFFFFFE;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic o_ready;
    logic o_valid;
    logic coef_load = 1'b0;
    logic clear = 1'b0;
    logic signed [31:0] i_data = '0;
    logic signed [31:0] o_data;
    logic signed [31:0] b0 = '0, b1 = '0, b2 = '0, a1 = '0, a2 = '0;

    biquad_df1 dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_coef_load (coef_load),
        .i_b0        (b0),
        .i_b1        (b1),
        .i_b2        (b2),
        .i_a1        (a1),
        .i_a2        (a2),
        .i_clear     (clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 due;
        logic signed [31:0] y;
        bit                 lit_en;
        logic signed [31:0] lit;
    } exp_t;

    exp_t exp_q[$];
    int   edge_no = 0;
    int   busy_until = 0;
    logic signed [31:0] sh[5];
    logic signed [31:0] ac[5];
    logic signed [31:0] hx1 = '0, hx2 = '0, hy1 = '0, hy2 = '0;
    logic signed [31:0] cur_x = '0, cur_y = '0;
    bit   pend = 1'b0, clr_pend = 1'b0;
    bit   nxt_lit_en = 1'b0;
    logic signed [31:0] nxt_lit = '0;
    int   checks = 0, errors = 0;
    bit   chk_en = 1'b0;
    int   rst_chk_edge = -1;

    function automatic logic signed [127:0] wx(input logic signed [31:0] v);
        return 128'(v);
    endfunction

    // y = (b0 x + b1 x1 + b2 x2 - a1 y1 - a2 y2) / 2^Q, floored, then clamp or wrap.
    function automatic logic signed [31:0] model_y(input logic signed [31:0] x);
        logic signed [127:0] s;
        logic signed [127:0] q;
        s = wx(ac[0]) * wx(x) + wx(ac[1]) * wx(hx1) + wx(ac[2]) * wx(hx2)
          - wx(ac[3]) * wx(hy1) - wx(ac[4]) * wx(hy2);
        q = s >>> Q;
`ifdef BIQUAD_SAT_EN
        if (q > 128'sd2147483647) return 32'sh7FFFFFFF;
        if (q < -128'sd2147483648) return 32'sh80000000;
`endif
        return q[31:0];
    endfunction

    always @(posedge clk) begin : mon
        bit idle;
        edge_no = edge_no + 1;
        idle = (edge_no - 1) >= busy_until;
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                sh[i] = '0;
                ac[i] = '0;
            end
            sh[0] = 32'sd1 <<< Q;
            ac[0] = 32'sd1 <<< Q;
            hx1 = '0; hx2 = '0; hy1 = '0; hy2 = '0;
            pend = 1'b0;
            clr_pend = 1'b0;
            busy_until = edge_no;
            exp_q.delete();
        end else begin
            if (coef_load) sh = '{b0, b1, b2, a1, a2};
            if (pend && !idle && clear) clr_pend = 1'b1;
            if (pend && edge_no == busy_until) begin
                if (clr_pend) begin
                    hx1 = '0; hx2 = '0; hy1 = '0; hy2 = '0;
                end else begin
                    hx2 = hx1; hx1 = cur_x; hy2 = hy1; hy1 = cur_y;
                end
                pend = 1'b0;
                clr_pend = 1'b0;
            end
            if (idle && clear) begin
                hx1 = '0; hx2 = '0; hy1 = '0; hy2 = '0;
            end
            if (idle && i_valid) begin
                ac = sh;
                cur_x = i_data;
                cur_y = model_y(i_data);
                exp_q.push_back('{edge_no + 6, cur_y, nxt_lit_en, nxt_lit});
                busy_until = edge_no + 6;
                pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        bit ev;
        bit er;
        if (chk_en) begin
            ev = (exp_q.size() > 0) && (exp_q[0].due == edge_no);
            er = (edge_no >= busy_until);
            checks++;
            if (o_ready !== er) begin
                errors++;
                $display("FAIL ready edge %0d: got %b want %b", edge_no, o_ready, er);
            end
            checks++;
            if (o_valid !== ev) begin
                errors++;
                $display("FAIL valid edge %0d: got %b want %b", edge_no, o_valid, ev);
            end
            if (ev) begin
                checks++;
                if (o_data !== exp_q[0].y) begin
                    errors++;
                    $display("FAIL y_model edge %0d: got %0d want %0d",
                             edge_no, o_data, exp_q[0].y);
                end
                if (exp_q[0].lit_en) begin
                    checks++;
                    if (o_data !== exp_q[0].lit) begin
                        errors++;
                        $display("FAIL y_lit edge %0d: got %0d want %0d",
                                 edge_no, o_data, exp_q[0].lit);
                    end
                end
                void'(exp_q.pop_front());
            end
            if (edge_no == rst_chk_edge) begin
                checks++;
                if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== 32'sd0) begin
                    errors++;
                    $display("FAIL reset_state: got v=%b r=%b d=%0d want v=0 r=1 d=0",
                             o_valid, o_ready, o_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        while (edge_no < busy_until) tick();
    endtask

    task automatic load(input logic signed [31:0] c0, input logic signed [31:0] c1,
                        input logic signed [31:0] c2, input logic signed [31:0] c3,
                        input logic signed [31:0] c4, input bit clr);
        wait_idle();
        b0 = c0; b1 = c1; b2 = c2; a1 = c3; a2 = c4;
        coef_load = 1'b1;
        clear = clr;
        tick();
        coef_load = 1'b0;
        clear = 1'b0;
    endtask

    task automatic send(input logic signed [31:0] x, input bit le,
                        input logic signed [31:0] lit);
        wait_idle();
        i_data = x;
        i_valid = 1'b1;
        nxt_lit_en = le;
        nxt_lit = lit;
        tick();
        i_valid = 1'b0;
        nxt_lit_en = 1'b0;
    endtask

    // kind 1: load b0=2.0, kind 2: clear, kind 3: reset; applied `at` edges after accept.
    task automatic send_act(input logic signed [31:0] x, input int at, input int kind,
                            input bit le, input logic signed [31:0] lit);
        send(x, le, lit);
        repeat (at - 1) tick();
        case (kind)
            1: begin
                b0 = 32'sd65536; b1 = '0; b2 = '0; a1 = '0; a2 = '0;
                coef_load = 1'b1;
            end
            2: clear = 1'b1;
            default: rst_n = 1'b0;
        endcase
        tick();
        coef_load = 1'b0;
        clear = 1'b0;
        if (kind == 3) begin
            rst_n = 1'b1;
            rst_chk_edge = edge_no;
        end
    endtask

    initial begin
        logic signed [31:0] mix[6];
        mix = '{32'sd1000, -32'sd2000, 32'sd3000, 32'sd0, 32'sd0, -32'sd7};
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        rst_chk_edge = edge_no;
        chk_en = 1'b1;

        send(1000, 1'b1, 1000);

        load(0, 16384, 0, 0, 0, 1'b1);
        send(32768, 1'b1, 0);
        send(0, 1'b1, 16384);

        load(32768, 0, 0, -16384, 0, 1'b1);
        send(1000, 1'b1, 1000);
        send(0, 1'b1, 500);
        send(0, 1'b1, 250);

        load(65536, 0, 0, 0, 0, 1'b1);
        send(32'sh7FFFFFFF, 1'b1, BIGY);

        load(16384, 0, 0, 0, 0, 1'b1);
        send(-3, 1'b1, -2);

        load(8192, 16384, 8192, -8192, 4096, 1'b1);
        for (int i = 0; i < 6; i++) send(mix[i], 1'b0, 0);

        load(32768, 32768, 0, 0, 0, 1'b1);
        send(10, 1'b1, 10);
        send_act(20, 3, 2, 1'b1, 30);
        send(5, 1'b1, 5);

        load(32768, 0, 0, 0, 0, 1'b1);
        send_act(100, 2, 1, 1'b1, 100);
        send(100, 1'b1, 200);

        wait_idle();
        i_data = 5;
        i_valid = 1'b1;
        repeat (16) tick();
        i_valid = 1'b0;

        load(32768, 0, 0, 0, 0, 1'b1);
        send_act(50, 3, 3, 1'b0, 0);
        repeat (8) tick();
        send(7, 1'b1, 7);

        wait_idle();
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
